// File: rtl/spike_train_generator_pkg.sv
// Shared definitions for spike_train_generator: FSM state encodings, LFSR taps,
// the LFSR step function and the period_packed channel-slice macro.
package spike_train_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } stg_state_e;

  // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

`ifndef STG_PERIOD_SLICE
`define STG_PERIOD_SLICE(vec, c, w) vec[(c)*(w) +: (w)]
`endif

// File: rtl/stg_channel.sv
// One input channel: period register, countdown counter with reload on fire and
// registered spike bit. Under STG_STOCHASTIC_EN a 16-bit LFSR makes the code a rate.
module stg_channel
  import spike_train_generator_pkg::*;
#(
  parameter int PER_W = 8
`ifdef STG_STOCHASTIC_EN
  ,
  parameter int          CH_IDX    = 0,
  parameter logic [15:0] SEED_BASE = 16'hACE1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [PER_W-1:0] period_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             reinit_i,
`ifdef STG_STOCHASTIC_EN
  input  logic             mode_i,
`endif
  output logic             spike_o
);

  logic [PER_W-1:0] period_q, period_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             spike_q, spike_d;
  logic             fire;

`ifdef STG_STOCHASTIC_EN
  localparam logic [15:0] SEED_RAW = SEED_BASE ^ 16'(CH_IDX);
  localparam logic [15:0] SEED     = (SEED_RAW == 16'd0) ? 16'd1 : SEED_RAW;
  logic [15:0] lfsr_q, lfsr_d;
`endif

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    period_d = load_i ? period_i : period_q;
    cnt_d    = cnt_q;
    spike_d  = spike_q;
    fire     = (period_q != '0) && (cnt_q <= PER_W'(1));
`ifdef STG_STOCHASTIC_EN
    lfsr_d   = lfsr_q;
    if (mode_i) fire = (lfsr_q[PER_W-1:0] < period_q);
`endif
    if (start_i) begin
      // period_d already selects the incoming code when load and start coincide
      cnt_d   = period_d;
      spike_d = 1'b0;
`ifdef STG_STOCHASTIC_EN
      lfsr_d  = SEED;
`endif
    end else if (step_i) begin
      spike_d = fire;
      if (reinit_i) begin
        cnt_d = period_q;
      end else if (period_q != '0) begin
        cnt_d = (cnt_q <= PER_W'(1)) ? period_q : cnt_q - PER_W'(1);
      end
`ifdef STG_STOCHASTIC_EN
      lfsr_d = reinit_i ? SEED : lfsr_next(lfsr_q);
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= '0;
      cnt_q    <= '0;
      spike_q  <= 1'b0;
`ifdef STG_STOCHASTIC_EN
      lfsr_q   <= SEED;
`endif
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      spike_q  <= spike_d;
`ifdef STG_STOCHASTIC_EN
      lfsr_q   <= lfsr_d;
`endif
    end
  end

  assign spike_o = spike_q;

endmodule

// File: rtl/spike_train_generator.sv
// Spike train generator top: IDLE/RUN/DONE FSM, time-unit counter and handshakes
// around NUM_CH stg_channel instances. Optional stochastic mode: STG_STOCHASTIC_EN.
module spike_train_generator
  import spike_train_generator_pkg::*;
#(
  parameter int NUM_CH       = 784,
  parameter int PER_W        = 8,
  parameter int TU_W         = 8,
  parameter int WINDOW       = 200,
  parameter bit AUTO_RESTART = 1'b1
`ifdef STG_STOCHASTIC_EN
  ,
  parameter logic [15:0] SEED_BASE = 16'hACE1
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*PER_W-1:0] period_packed,
  input  logic                    load,
  input  logic                    start,
  input  logic                    step,
`ifdef STG_STOCHASTIC_EN
  input  logic                    mode,
`endif
  output logic [NUM_CH-1:0]       spikes_out,
  output logic                    spike_valid,
  output logic                    window_done,
  output logic [TU_W-1:0]         tu_count,
  output logic                    busy
);

  localparam logic [TU_W-1:0] LAST_TU = TU_W'(WINDOW - 1);
  localparam logic [TU_W-1:0] FULL_TU = TU_W'(WINDOW);

  stg_state_e      state_q, state_d;
  logic [TU_W-1:0] tu_count_q, tu_count_d;
  logic            spike_valid_q, spike_valid_d;
  logic            window_done_q, window_done_d;
  logic            step_run;
  logic            reinit;
`ifdef STG_STOCHASTIC_EN
  logic            mode_q;
`endif

  always_comb begin
    state_d       = state_q;
    tu_count_d    = tu_count_q;
    spike_valid_d = 1'b0;
    window_done_d = 1'b0;
    step_run      = 1'b0;
    reinit        = 1'b0;
    if (start) begin
      // start wins over a coincident step, which is dropped
      state_d    = ST_RUN;
      tu_count_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (step) begin
            step_run      = 1'b1;
            spike_valid_d = 1'b1;
            if (tu_count_q == LAST_TU) begin
              window_done_d = 1'b1;
              if (AUTO_RESTART) begin
                tu_count_d = '0;
                reinit     = 1'b1;
              end else begin
                tu_count_d = FULL_TU;
                state_d    = ST_DONE;
              end
            end else begin
              tu_count_d = tu_count_q + TU_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tu_count_q    <= '0;
      spike_valid_q <= 1'b0;
      window_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tu_count_q    <= tu_count_d;
      spike_valid_q <= spike_valid_d;
      window_done_q <= window_done_d;
    end
  end

`ifdef STG_STOCHASTIC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else if (start) begin
      mode_q <= mode;
    end
  end
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    stg_channel #(
      .PER_W(PER_W)
`ifdef STG_STOCHASTIC_EN
      ,
      .CH_IDX   (c),
      .SEED_BASE(SEED_BASE)
`endif
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .period_i(`STG_PERIOD_SLICE(period_packed, c, PER_W)),
      .start_i (start),
      .step_i  (step_run),
      .reinit_i(reinit),
`ifdef STG_STOCHASTIC_EN
      .mode_i  (mode_q),
`endif
      .spike_o (spikes_out[c])
    );
  end

  assign spike_valid = spike_valid_q;
  assign window_done = window_done_q;
  assign tu_count    = tu_count_q;
  assign busy        = (state_q == ST_RUN);

endmodule
